opamp_diff_array: RTL

Parametrised, clocked successor to the single-channel differential op-amp stage. It scans `CHANNELS` differential input pairs round-robin. For each channel it computes the gained difference `v_plus - v_minus` and drives the result as a complementary `output_plus` / `output_minus` pair over a valid/ready handshake. A per-channel integrator mode accumulates differences across visits. The block sits between the differential qubit front-ends and downstream digit-supply consumers.

---
 rtl/opamp_diff_pkg.sv | 32 +++
 rtl/opamp_sat_add.sv | 44 ++++
 rtl/opamp_diff_array.sv | 117 +++++++++++
 3 files changed

// File: rtl/opamp_diff_pkg.sv
// rtl/opamp_diff_pkg.sv - shared types and helpers for the differential op-amp array
//
// Purpose: scan FSM state type, symmetric clamp helper and channel-index width helper.
// Ports:   none (package).

package opamp_diff_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // Clamp v into [-(2^(w-1)-1), +(2^(w-1)-1)]; caller keeps the low w bits.
  // The most-negative code is excluded so that negation always fits.
  function automatic logic signed [MAX_W-1:0] clamp_sym(input logic signed [MAX_W-1:0] v,
                                                       input int w);
    logic signed [MAX_W-1:0] lim;
    lim = (64'sd1 <<< (w - 1)) - 64'sd1;
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  // Width of a channel index; a single channel still needs one bit.
  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/opamp_sat_add.sv
// rtl/opamp_sat_add.sv - difference, gain shift, optional accumulate and symmetric clamp
//
// Purpose: combinational datapath shared by all channels of opamp_diff_array.
// Ports:   a_i/b_i      unsigned plus/minus lanes
//          acc_i        signed accumulator operand
//          use_acc_i    add acc_i to the shifted difference
//          r_o          clamped signed result
//          sat_o        clamp changed the value

module opamp_sat_add
  import opamp_diff_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int GAIN_SHIFT = 0,
  parameter int ACC_WIDTH  = 12
) (
  input  logic [WIDTH-1:0]            a_i,
  input  logic [WIDTH-1:0]            b_i,
  input  logic signed [ACC_WIDTH-1:0] acc_i,
  input  logic                        use_acc_i,
  output logic signed [ACC_WIDTH-1:0] r_o,
  output logic                        sat_o
);

  // Wide enough that neither the shift nor the add can wrap before clamping.
  localparam int IW = ACC_WIDTH + GAIN_SHIFT + 2;

  logic signed [WIDTH:0]       diff;
  logic signed [IW-1:0]        d_ext;
  logic signed [IW-1:0]        acc_ext;
  logic signed [IW-1:0]        sum;
  logic signed [MAX_W-1:0]     sum_wide;
  logic signed [MAX_W-1:0]     clamped;

  assign diff     = $signed({1'b0, a_i}) - $signed({1'b0, b_i});
  assign d_ext    = IW'(diff) <<< GAIN_SHIFT;
  assign acc_ext  = use_acc_i ? IW'(acc_i) : '0;
  assign sum      = d_ext + acc_ext;
  assign sum_wide = MAX_W'(sum);
  assign clamped  = clamp_sym(sum_wide, ACC_WIDTH);
  assign r_o      = clamped[ACC_WIDTH-1:0];
  assign sat_o    = (clamped != sum_wide);

endmodule

// File: rtl/opamp_diff_array.sv
// rtl/opamp_diff_array.sv - round-robin differential amplifier / integrator array
//
// Purpose: scans CHANNELS differential pairs, emits gained difference (or running
//          integral) as a complementary pair over a valid/ready handshake.
// Ports:   clk, rst             clock, synchronous active-high reset
//          receive              enables scanning
//          mode                 0 follower, 1 integrator (read in SAMPLE only)
//          acc_clr              clears all accumulators
//          v_plus/v_minus       packed input lanes, channel 0 in the LSBs
//          out_ready            downstream accepts
//          out_valid, out_chan  result valid and its channel
//          output_plus/minus    signed result and its negation
//          sat                  result was clamped

module opamp_diff_array
  import opamp_diff_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 8,
  parameter int GAIN_SHIFT = 0,
  parameter int ACC_WIDTH  = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          receive,
  input  logic                          mode,
  input  logic                          acc_clr,
  input  logic [CHANNELS*WIDTH-1:0]     v_plus,
  input  logic [CHANNELS*WIDTH-1:0]     v_minus,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [chan_w(CHANNELS)-1:0]   out_chan,
  output logic signed [ACC_WIDTH-1:0]   output_plus,
  output logic signed [ACC_WIDTH-1:0]   output_minus,
  output logic                          sat
);

  localparam int            CW        = chan_w(CHANNELS);
  localparam logic [CW-1:0] LAST_CHAN = CW'(CHANNELS - 1);

  state_t                       state_q, state_d;
  logic [CW-1:0]                chan_q, chan_d;
  logic signed [ACC_WIDTH-1:0]  acc_q [CHANNELS];
  logic [WIDTH-1:0]             lane_plus, lane_minus;
  logic signed [ACC_WIDTH-1:0]  acc_sel;
  logic signed [ACC_WIDTH-1:0]  r;
  logic                         r_sat;
  logic                         sampling;
  logic                         handshake;

  assign lane_plus  = v_plus[chan_q*WIDTH +: WIDTH];
  assign lane_minus = v_minus[chan_q*WIDTH +: WIDTH];
  // A clear during SAMPLE makes this visit integrate from zero.
  assign acc_sel    = acc_clr ? '0 : acc_q[chan_q];
  assign sampling   = (state_q == ST_SAMPLE);
  assign handshake  = (state_q == ST_HOLD) && out_valid && out_ready;

  opamp_sat_add #(
    .WIDTH      (WIDTH),
    .GAIN_SHIFT (GAIN_SHIFT),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_sat_add (
    .a_i       (lane_plus),
    .b_i       (lane_minus),
    .acc_i     (acc_sel),
    .use_acc_i (mode),
    .r_o       (r),
    .sat_o     (r_sat)
  );

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    case (state_q)
      ST_IDLE:   if (receive) state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = ST_HOLD;
      ST_HOLD: begin
        if (handshake) begin
          chan_d  = (chan_q == LAST_CHAN) ? '0 : chan_q + 1'b1;
          state_d = receive ? ST_SAMPLE : ST_IDLE;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      chan_q       <= '0;
      for (int i = 0; i < CHANNELS; i++) acc_q[i] <= '0;
      out_valid    <= 1'b0;
      out_chan     <= '0;
      output_plus  <= '0;
      output_minus <= '0;
      sat          <= 1'b0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      if (acc_clr) begin
        for (int i = 0; i < CHANNELS; i++) acc_q[i] <= '0;
      end
      if (sampling) begin
        // Written after the clear loop so the fresh value wins for this channel.
        if (mode) acc_q[chan_q] <= r;
        output_plus  <= r;
        output_minus <= -r;
        out_chan     <= chan_q;
        sat          <= r_sat;
        out_valid    <= 1'b1;
      end else if (handshake) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
